// File: rtl/onewire_rom_crc_check_if.sv
// rtl/onewire_rom_crc_check_if.sv - bit-serial ROM-code receive interface
//
// Purpose: bundles the sampler-facing bit stream and the controller-facing
// result signals of the 1-Wire ROM-code checker.
// Signals:
//   start        begin a new frame (1-cycle pulse)
//   bit_in       received bit, qualified by bit_valid
//   bit_valid    bit_in valid this cycle
//   busy         frame in progress
//   done         1-cycle pulse: frame complete or aborted
//   crc_ok       residue check passed, held until next done
//   timeout_err  last frame aborted on inter-bit timeout, held until next done
//   addr_out     assembled ROM code, first received bit in the MSB
// Modports: master drives the bit stream, slave is the checker.

interface onewire_rom_crc_check_if #(
  parameter int ADDR_BITS = 64
);
  logic                 start;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 busy;
  logic                 done;
  logic                 crc_ok;
  logic                 timeout_err;
  logic [ADDR_BITS-1:0] addr_out;

  modport master (
    output start, bit_in, bit_valid,
    input  busy, done, crc_ok, timeout_err, addr_out
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output busy, done, crc_ok, timeout_err, addr_out
  );
endinterface

// File: rtl/onewire_rom_crc_check.sv
// rtl/onewire_rom_crc_check.sv - 1-Wire ROM code receiver with CRC-8 residue check
//
// Purpose: shifts in a 64-bit ROM code one bit per bit_valid, runs the
// CRC-8 (x^8+x^5+x^4+1) residue over the whole frame and reports the result
// with the assembled address. Aborts on an inter-bit timeout.
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, active low
//   bus    slave side of onewire_rom_crc_check_if (stream in, result out)
// Optional feature: define ZERO_REJECT_EN to fail an all-zero frame
// (bus stuck low) even though its residue is zero.

module onewire_rom_crc_check #(
  parameter int         ADDR_BITS   = 64,
  parameter logic [7:0] POLY        = 8'h31,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  onewire_rom_crc_check_if.slave   bus
);

  localparam int CNT_W  = $clog2(ADDR_BITS);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(ADDR_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            crc_q, crc_d;
  logic [ADDR_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic                  crc_ok_q, crc_ok_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  fb;
  logic [7:0]            crc_next;
  logic [ADDR_BITS-1:0]  shift_next;
  logic                  zero_ok;

  // Direct-form MSB-first CRC: a frame carrying its own CRC leaves residue 0.
  assign fb         = crc_q[7] ^ bus.bit_in;
  assign crc_next   = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  assign shift_next = {shift_q[ADDR_BITS-2:0], bus.bit_in};

`ifdef ZERO_REJECT_EN
  assign zero_ok = (shift_next != '0);
`else
  assign zero_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      crc_q         <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      addr_q        <= '0;
      crc_ok_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      addr_q        <= addr_d;
      crc_ok_q      <= crc_ok_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    addr_d        = addr_q;
    crc_ok_d      = crc_ok_q;
    timeout_err_d = timeout_err_q;

    // start wins over everything, including a bit_valid in the same cycle,
    // and silently abandons any frame in flight.
    if (bus.start) begin
      state_d    = ST_RECV;
      crc_d      = 8'h00;
      shift_d    = '0;
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (bus.bit_valid) begin
            crc_d      = crc_next;
            shift_d    = shift_next;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            idle_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d       = ST_DONE;
              addr_d        = shift_next;
              crc_ok_d      = (crc_next == 8'h00) && zero_ok;
              timeout_err_d = 1'b0;
            end
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
            // This idle cycle brings the count to TIMEOUT_CYC.
            if (idle_cnt_q == IDLE_LIM) begin
              state_d       = ST_DONE;
              addr_d        = shift_q;
              crc_ok_d      = 1'b0;
              timeout_err_d = 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  assign bus.busy        = (state_q == ST_RECV);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.crc_ok      = crc_ok_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.addr_out    = addr_q;

endmodule
